// File: rtl/gpu_ram_arb_pkg.sv
// gpu_ram_arb_pkg: read-tag encoding and constants shared by the GPU RAM arbiter
package gpu_ram_arb_pkg;
  typedef enum logic [1:0] {TAG_NONE, TAG_HOST, TAG_HOST_OOR, TAG_AUX} rd_tag_e;
  localparam logic [7:0] OOR_READ_DATA = 8'hFF;
endpackage

// File: rtl/gpu_ram_arbiter_rd_tag_pipe.sv
// rd_tag_pipe: delays each RAM-cycle read tag so it meets the matching ram_rdata
module rd_tag_pipe
  import gpu_ram_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    GPU_CLK,
  input  logic    reset,
  input  rd_tag_e tag_in,
  output rd_tag_e tag_out
);
  rd_tag_e stage [DEPTH];
  always_ff @(posedge GPU_CLK or negedge reset)
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= TAG_NONE;
    end else begin
      stage[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  assign tag_out = stage[DEPTH-1];
endmodule

// File: rtl/gpu_ram_arbiter.sv
// gpu_ram_arbiter: shares the GPU RAM port between Z80 host strobes and an aux req/gnt requester
module gpu_ram_arbiter
  import gpu_ram_arb_pkg::*;
#(
  parameter int ADDR_BITS        = 20,
  parameter int MEM_SIZE_BITS    = 15,
  parameter int READ_LATENCY     = 2,
  parameter int AUX_STARVE_LIMIT = 4
) (
  input  logic                     GPU_CLK,
  input  logic                     reset,
  input  logic                     host_wr_ena,
  input  logic                     host_rd_req,
  input  logic [ADDR_BITS-1:0]     host_addr,
  input  logic [7:0]               host_wdata,
  output logic                     host_rd_rdy,
  output logic [7:0]               host_rdata,
  output logic                     host_overrun,
  input  logic                     aux_req,
  input  logic                     aux_we,
  input  logic [ADDR_BITS-1:0]     aux_addr,
  input  logic [7:0]               aux_wdata,
  output logic                     aux_gnt,
  output logic                     aux_rvalid,
  output logic [7:0]               aux_rdata,
  output logic [MEM_SIZE_BITS-1:0] ram_addr,
  output logic                     ram_we,
  output logic [7:0]               ram_wdata,
  input  logic [7:0]               ram_rdata
);
  localparam int SW = $clog2(AUX_STARVE_LIMIT + 1);
  logic                 wr_pend, rd_pend;
  logic [ADDR_BITS-1:0] wr_addr, rd_addr;
  logic [7:0]           wr_data;
  logic [SW-1:0]        starve_cnt;
  rd_tag_e              ram_tag, tag_out;
  logic                 wr_oor, rd_oor, wr_ok, starved, aux_xfer, gnt_wr, gnt_rd;
  logic                 aux_addr_unused;
  assign aux_addr_unused = ^aux_addr;
  assign wr_oor   = (wr_addr >> MEM_SIZE_BITS) != '0;
  assign rd_oor   = (rd_addr >> MEM_SIZE_BITS) != '0;
  // an out-of-range write is dropped without taking the RAM cycle
  assign wr_ok    = wr_pend && !wr_oor;
  assign starved  = starve_cnt == SW'(AUX_STARVE_LIMIT);
  assign aux_gnt  = reset && (!(wr_ok || rd_pend) || starved);
  assign aux_xfer = aux_req && aux_gnt;
  assign gnt_wr   = wr_ok && !aux_xfer;
  assign gnt_rd   = rd_pend && !wr_ok && !aux_xfer;
  always_ff @(posedge GPU_CLK or negedge reset)
    if (!reset) begin
      wr_pend      <= 1'b0;
      rd_pend      <= 1'b0;
      wr_addr      <= '0;
      rd_addr      <= '0;
      wr_data      <= '0;
      starve_cnt   <= '0;
      host_overrun <= 1'b0;
      ram_we       <= 1'b0;
      ram_addr     <= '0;
      ram_wdata    <= '0;
      ram_tag      <= TAG_NONE;
      host_rd_rdy  <= 1'b0;
      host_rdata   <= '0;
      aux_rvalid   <= 1'b0;
      aux_rdata    <= '0;
    end else begin
      wr_pend      <= host_wr_ena || (wr_ok && !gnt_wr);
      rd_pend      <= host_rd_req || (rd_pend && !gnt_rd);
      if (host_wr_ena) begin
        wr_addr <= host_addr;
        wr_data <= host_wdata;
      end
      if (host_rd_req) rd_addr <= host_addr;
      host_overrun <= (host_wr_ena && wr_ok && !gnt_wr) || (host_rd_req && rd_pend && !gnt_rd);
      starve_cnt   <= (!aux_req || aux_xfer) ? '0 :
                      ((gnt_wr || gnt_rd) && !starved) ? starve_cnt + SW'(1) : starve_cnt;
      ram_we       <= gnt_wr || (aux_xfer && aux_we);
      if (gnt_wr) begin
        ram_addr  <= wr_addr[MEM_SIZE_BITS-1:0];
        ram_wdata <= wr_data;
      end else if (gnt_rd) begin
        ram_addr  <= rd_addr[MEM_SIZE_BITS-1:0];
      end else if (aux_xfer) begin
        ram_addr  <= aux_addr[MEM_SIZE_BITS-1:0];
        ram_wdata <= aux_wdata;
      end
      ram_tag      <= gnt_rd ? (rd_oor ? TAG_HOST_OOR : TAG_HOST) :
                      (aux_xfer && !aux_we) ? TAG_AUX : TAG_NONE;
      host_rd_rdy  <= tag_out == TAG_HOST || tag_out == TAG_HOST_OOR;
      aux_rvalid   <= tag_out == TAG_AUX;
      if (tag_out == TAG_HOST) host_rdata <= ram_rdata;
      else if (tag_out == TAG_HOST_OOR) host_rdata <= OOR_READ_DATA;
      if (tag_out == TAG_AUX) aux_rdata <= ram_rdata;
    end
  // ram_tag is aligned with ram_addr; the pipe adds the RAM read latency
  rd_tag_pipe #(.DEPTH(READ_LATENCY)) u_tag_pipe (
    .GPU_CLK (GPU_CLK),
    .reset   (reset),
    .tag_in  (ram_tag),
    .tag_out (tag_out)
  );
endmodule

// File: tb/tb_gpu_ram_arbiter.sv
// tb_gpu_ram_arbiter: directed steps with a read-data scoreboard and a 2-cycle RAM model
module tb_gpu_ram_arbiter;
  localparam int AB = 20, MB = 15;
  logic          GPU_CLK = 1'b0;
  logic          reset;
  logic          host_wr_ena, host_rd_req, host_rd_rdy, host_overrun;
  logic [AB-1:0] host_addr, aux_addr;
  logic [7:0]    host_wdata, host_rdata, aux_wdata, aux_rdata, ram_wdata, ram_rdata, p1;
  logic          aux_req, aux_we, aux_gnt, aux_rvalid, ram_we;
  logic [MB-1:0] ram_addr;
  logic [43:0]   all_out;
  logic [7:0]    mem [2**MB];
  bit            loaded = 1'b0;
  logic [7:0]    host_q [$];
  logic [7:0]    aux_q [$];
  int            checks = 0, errors = 0;
  int            we_cnt = 0, ov_cnt = 0, rdy_cnt = 0, rv_cnt = 0;
  int            b_we, b_ov, b_rdy, b_rv;

  always #4 GPU_CLK = ~GPU_CLK;

  gpu_ram_arbiter dut (
    .GPU_CLK(GPU_CLK), .reset(reset),
    .host_wr_ena(host_wr_ena), .host_rd_req(host_rd_req), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_rd_rdy(host_rd_rdy), .host_rdata(host_rdata),
    .host_overrun(host_overrun), .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr),
    .aux_wdata(aux_wdata), .aux_gnt(aux_gnt), .aux_rvalid(aux_rvalid), .aux_rdata(aux_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  assign all_out = {host_rd_rdy, host_rdata, host_overrun, aux_gnt, aux_rvalid, aux_rdata,
                    ram_addr, ram_we, ram_wdata};

  function automatic logic [7:0] pat(input int a);
    return 8'(a) ^ 8'h4A;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge GPU_CLK);
      #1;
    end
  endtask

  // RAM: data valid two cycles after its address
  always @(posedge GPU_CLK) begin
    if (!loaded) begin
      for (int i = 0; i < 2**MB; i++) mem[i] <= pat(i);
      loaded <= 1'b1;
    end else if (ram_we) mem[ram_addr] <= ram_wdata;
    p1        <= mem[ram_addr];
    ram_rdata <= p1;
  end

  always @(negedge GPU_CLK) if (reset) begin
    if (ram_we) we_cnt++;
    if (host_overrun) ov_cnt++;
    if (host_rd_rdy) begin
      rdy_cnt++;
      if (host_q.size() == 0) check("host_sb_empty", 64'(host_q.size()), 64'd1);
      else check("host_sb_rdata", 64'(host_rdata), 64'(host_q.pop_front()));
    end
    if (aux_rvalid) begin
      rv_cnt++;
      if (aux_q.size() == 0) check("aux_sb_empty", 64'(aux_q.size()), 64'd1);
      else check("aux_sb_rdata", 64'(aux_rdata), 64'(aux_q.pop_front()));
    end
  end

  initial begin
    reset = 1'b0;
    {host_wr_ena, host_rd_req, aux_req, aux_we} = '0;
    host_addr = '0; host_wdata = '0; aux_addr = '0; aux_wdata = '0;
    tick(3);
    check("reset_outputs", 64'(all_out), 64'd0);
    reset = 1'b1;
    tick(2);
    check("idle_aux_gnt", 64'(aux_gnt), 64'd1);

    // single host read
    b_rv = rv_cnt;
    host_addr = 20'h00010; host_rd_req = 1'b1; host_q.push_back(8'h5A);
    tick; host_rd_req = 1'b0;
    tick;
    check("t1_ram_addr", 64'(ram_addr), 64'h10);
    check("t1_ram_we", 64'(ram_we), 64'd0);
    tick(2);
    check("t1_rdy_early", 64'(host_rd_rdy), 64'd0);
    tick;
    check("t1_rdy", 64'(host_rd_rdy), 64'd1);
    check("t1_rdata", 64'(host_rdata), 64'h5A);
    tick;
    check("t1_rdy_pulse", 64'(host_rd_rdy), 64'd0);
    check("t1_no_aux", 64'(rv_cnt - b_rv), 64'd0);

    // write and read strobes together
    host_addr = 20'h00020; host_wdata = 8'h33; host_wr_ena = 1'b1; host_rd_req = 1'b1;
    host_q.push_back(8'h33);
    tick; {host_wr_ena, host_rd_req} = 2'b00;
    tick;
    check("t2_wr", 64'({ram_we, ram_addr, ram_wdata}), 64'({1'b1, 15'h20, 8'h33}));
    tick;
    check("t2_rd_addr", 64'({ram_we, ram_addr}), 64'({1'b0, 15'h20}));
    tick(2);
    check("t2_rdy_early", 64'(host_rd_rdy), 64'd0);
    tick;
    check("t2_rdata", 64'({host_rd_rdy, host_rdata}), 64'({1'b1, 8'h33}));

    // out-of-range read and write
    b_we = we_cnt;
    host_addr = 20'h08000; host_rd_req = 1'b1; host_q.push_back(8'hFF);
    tick; host_rd_req = 1'b0;
    tick(3);
    check("t3_rdy_early", 64'(host_rd_rdy), 64'd0);
    tick;
    check("t3_oor_rdata", 64'({host_rd_rdy, host_rdata}), 64'({1'b1, 8'hFF}));
    host_wdata = 8'h99; host_wr_ena = 1'b1;
    tick; host_wr_ena = 1'b0;
    tick(5);
    check("t3_no_ram_we", 64'(we_cnt - b_we), 64'd0);

    // aux starvation guard
    for (int i = 0; i < 5; i++) begin
      host_addr = 20'h100 + AB'(i); host_wdata = 8'(i + 1); host_wr_ena = 1'b1;
      if (i == 1) begin
        aux_req = 1'b1; aux_we = 1'b1; aux_addr = 20'hF0200; aux_wdata = 8'hC3;
      end
      if (i >= 1) check("t4_gnt_wait", 64'(aux_gnt), 64'd0);
      tick;
    end
    host_wr_ena = 1'b0;
    check("t4_gnt_forced", 64'(aux_gnt), 64'd1);
    tick; aux_req = 1'b0;
    check("t4_aux_wr", 64'({ram_we, ram_addr, ram_wdata}), 64'({1'b1, 15'h200, 8'hC3}));
    check("t4_starve_clr", 64'(dut.starve_cnt), 64'd0);
    tick;
    check("t4_host_resume", 64'({ram_we, ram_addr, ram_wdata}), 64'({1'b1, 15'h104, 8'h05}));
    tick;
    aux_req = 1'b1; aux_we = 1'b0; aux_addr = 20'h00200; aux_q.push_back(8'hC3);
    check("t4_rd_gnt", 64'(aux_gnt), 64'd1);
    tick; aux_req = 1'b0;
    tick(2);
    check("t4_rv_early", 64'(aux_rvalid), 64'd0);
    tick;
    check("t4_aux_rdata", 64'({aux_rvalid, aux_rdata}), 64'({1'b1, 8'hC3}));
    host_addr = 20'h103; host_rd_req = 1'b1; host_q.push_back(8'h04);
    tick; host_rd_req = 1'b0;
    tick(6);

    // overrun while rd_pend waits behind a forced aux slot
    b_ov = ov_cnt; b_rdy = rdy_cnt;
    for (int i = 0; i < 6; i++) begin
      host_wr_ena = i < 4;
      host_rd_req = i >= 4;
      host_addr   = i < 4 ? 20'h110 + AB'(i) : (i == 4 ? 20'h44 : 20'h55);
      if (i == 1) begin
        aux_req = 1'b1; aux_we = 1'b1; aux_addr = 20'h300; aux_wdata = 8'h77;
      end
      if (i == 5) check("t5_gnt_forced", 64'(aux_gnt), 64'd1);
      tick;
    end
    {host_wr_ena, host_rd_req, aux_req} = 3'b000;
    host_q.push_back(pat(20'h55));
    check("t5_overrun", 64'(host_overrun), 64'd1);
    tick(4);
    check("t5_rdata", 64'({host_rd_rdy, host_rdata}), 64'({1'b1, pat(20'h55)}));
    tick(3);
    check("t5_overrun_cnt", 64'(ov_cnt - b_ov), 64'd1);
    check("t5_rdy_cnt", 64'(rdy_cnt - b_rdy), 64'd1);

    // reset with a host and an aux read in flight
    b_rdy = rdy_cnt; b_rv = rv_cnt;
    host_addr = 20'h60; host_rd_req = 1'b1;
    aux_req = 1'b1; aux_we = 1'b0; aux_addr = 20'h70;
    tick; {host_rd_req, aux_req} = 2'b00;
    tick;
    reset = 1'b0;
    #1;
    check("t6_reset_outputs", 64'(all_out), 64'd0);
    tick(2);
    reset = 1'b1;
    tick(8);
    check("t6_no_host_rdy", 64'(rdy_cnt - b_rdy), 64'd0);
    check("t6_no_aux_rv", 64'(rv_cnt - b_rv), 64'd0);
    host_addr = 20'h7A; host_rd_req = 1'b1; host_q.push_back(pat(20'h7A));
    tick; host_rd_req = 1'b0;
    tick(3);
    check("t6_rdy_early", 64'(host_rd_rdy), 64'd0);
    tick;
    check("t6_rdata", 64'({host_rd_rdy, host_rdata}), 64'({1'b1, pat(20'h7A)}));
    tick(2);

    check("host_sb_drained", 64'(host_q.size()), 64'd0);
    check("aux_sb_drained", 64'(aux_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/gpu_ram_arbiter.md
# gpu_ram_arbiter

Shares the single GPU RAM port between the Z80 bus bridge (host: one-shot write/read strobes, no back-pressure) and an auxiliary GPU-side requester such as the blitter or geometry unit, which uses a req/gnt handshake. Host accesses have priority, bounded by a starvation guard for aux. Read data is returned to the requester that issued it, tracked by a latency-matched tag pipeline. The block sits between the Z80 bridge and the RAM in the GPU_CLK (125 MHz) domain.

## Interface
- ADDR_BITS, 20, width of host/aux address inputs
- MEM_SIZE_BITS, 15, RAM address width; host addresses ≥ 2**MEM_SIZE_BITS are out of range
- READ_LATENCY, 2, cycles from ram_addr presented to ram_rdata valid (≥1)
- AUX_STARVE_LIMIT, 4, consecutive host grants with aux_req pending before aux is forced a slot (≥1)

- GPU_CLK  in  1  sole clock
- reset  in  1  asynchronous, active-low
- host_wr_ena  in  1  one-cycle write strobe
- host_rd_req  in  1  one-cycle read strobe
- host_addr  in  ADDR_BITS  host address, sampled with either strobe
- host_wdata  in  8  sampled with host_wr_ena
- host_rd_rdy  out  1  one-cycle pulse, host_rdata valid
- host_rdata  out  8  read data for host
- host_overrun  out  1  one-cycle pulse, strobe arrived while same-type pending slot full
- aux_req  in  1  aux request; address/data/we held stable until accepted
- aux_we  in  1  1 = write, 0 = read
- aux_addr  in  ADDR_BITS  low MEM_SIZE_BITS used, upper bits ignored
- aux_wdata  in  8  aux write data
- aux_gnt  out  1  aux may transfer this cycle; transfer = aux_req && aux_gnt at the edge
- aux_rvalid  out  1  one-cycle pulse, aux_rdata valid
- aux_rdata  out  8  read data for aux
- ram_addr  out  MEM_SIZE_BITS  registered
- ram_we  out  1  registered, one cycle per write
- ram_wdata  out  8  registered
- ram_rdata  in  8  valid READ_LATENCY cycles after its address

## Operation
- Host capture: each strobe loads a 1-deep pending slot (wr_pend with addr/data; rd_pend with addr). Both strobes in the same cycle load both slots. A strobe into an occupied slot overwrites it (latest wins) and pulses host_overrun.
- Arbitration per cycle, one RAM access max, priority: wr_pend > rd_pend > aux. Exception: starve_cnt == AUX_STARVE_LIMIT and aux_req → aux wins.
- aux_gnt = (no host slot pending) || (starve_cnt == AUX_STARVE_LIMIT); does not depend on aux_req.
- starve_cnt: +1 per host grant while aux_req high (saturating at limit); cleared on aux transfer or whenever aux_req low.
- Out-of-range host write: slot cleared, ram_we stays 0, no RAM slot consumed. Out-of-range host read: consumes a slot with ram_we=0 and tag HOST_OOR; returns 8'hFF at normal latency.
- Every granted read pushes a tag (HOST, HOST_OOR, AUX) into the tag pipeline; a write or idle cycle pushes NONE. At the tag output, ram_rdata (or 8'hFF for HOST_OOR) is registered into the matching rdata and the matching rdy/rvalid pulses.
- Reset (asserted at any time): pending slots, starve_cnt and tag pipeline cleared; in-flight reads are dropped with no rdy/rvalid. All outputs reset to 0, including host_rdata/aux_rdata.

## Timing
- Host read uncontended: host_rd_req in cycle 0 → rd_pend cycle 1 → ram_addr cycle 2 → ram_rdata cycle 2+READ_LATENCY → host_rd_rdy/host_rdata cycle 3+READ_LATENCY (5 at default).
- Host write uncontended: strobe cycle 0 → ram_we/addr/wdata cycle 2, high one cycle.
- Aux transfer at edge ending cycle n → RAM access cycle n+1. Aux read data at n+2+READ_LATENCY.
- Max host wait: bounded by one forced aux slot per AUX_STARVE_LIMIT host grants.
- Sustained throughput: one access per cycle. Host rd_rdy order matches request order.

## Structure
- Package gpu_ram_arb_pkg: tag enum {TAG_NONE, TAG_HOST, TAG_HOST_OOR, TAG_AUX}; OOR_READ_DATA = 8'hFF.
- Sub-module rd_tag_pipe: READ_LATENCY-deep tag shift register with async active-low reset. Instantiated once.

## Test plan
- Single host read at addr 0x00010, RAM model returns 0x5A → host_rd_rdy in cycle 5, host_rdata=0x5A, aux_rvalid never pulses.
- Host write and read strobes in the same cycle, both to addr 0x00020, wdata 0x33 → ram_we in cycle 2, read address in cycle 3, host_rdata=0x33 in cycle 6.
- Host read at addr 0x08000 (out of range, MEM_SIZE_BITS=15) → ram_we=0, host_rdata=0xFF at normal latency. Host write to 0x08000 → no ram_we at all.
- aux_req held high while host strobes arrive every cycle → aux_gnt asserted on the cycle after 4 host grants; aux write lands in RAM; starve_cnt returns to 0.
- Second host_rd_req arrives before the first read is issued (rd_pend held by aux forced slot) → host_overrun pulses once; a single rd_rdy is returned, for the second address.
- reset driven low with two reads in flight → no rdy/rvalid after release, all outputs 0, next host read completes at normal latency.
